// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and defaults for the frame-buffer write arbiter.
// Build option: FBARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package fb_write_arbiter_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 32;
  localparam int GID_W     = 3;

  typedef enum logic {
    FBARB_STATE_IDLE  = 1'b0,
    FBARB_STATE_GRANT = 1'b1
  } fbarb_state_e;

  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first request after i_base, wrapping.
// With FBARB_FIXED_PRIO_EN defined the lowest asserted index wins and i_base is ignored.
module fb_write_arbiter_rr_pick
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_base,
  output logic [GID_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_rank;
  int w_best;

`ifdef FBARB_FIXED_PRIO_EN
  logic w_unused_base;
  assign w_unused_base = ^i_base;
`endif

  always_comb begin
    o_idx  = {GID_W{1'b0}};
    w_best = NUM_REQ;
    w_rank = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FBARB_FIXED_PRIO_EN
      w_rank = i;
`else
      // Distance from the slot just after the base, so the base itself ranks last.
      w_rank = (i + NUM_REQ - int'(i_base) - 1) % NUM_REQ;
`endif
      if (i_req[i] && (w_rank < w_best)) begin
        w_best = w_rank;
        o_idx  = GID_W'(i);
      end else begin
        w_best = w_best;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port between NUM_REQ generators with burst-locked grants.
// Build option: FBARB_FIXED_PRIO_EN (fixed priority, requester 0 highest).
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic [NUM_REQ-1:0]          req_rts,
  output logic [NUM_REQ-1:0]          req_rtr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wben,
  output logic                        mem_rts,
  input  logic                        mem_rtr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W/8-1:0]         mem_wben,
  output logic [2:0]                  grant_id,
  output logic                        busy
);

  localparam int WB_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = burst_cnt_w(MAX_BURST);

  fbarb_state_e      r_state, w_state_nxt;
  logic [GID_W-1:0]  r_grant_id, w_grant_nxt;
  logic [GID_W-1:0]  r_last_grant, w_last_nxt;
  logic [CNT_W-1:0]  r_burst_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_mem_rts;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic [WB_W-1:0]   r_mem_wben;

  logic [IDX_W-1:0]  w_gidx;
  logic [GID_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_slot_free;
  logic              w_rtr_en;
  logic              w_owner_rts;
  logic              w_req_xfc;
  logic              w_release;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [WB_W-1:0]   w_sel_wben;

  fb_write_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (req_rts),
    .i_base  (r_last_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_gidx      = r_grant_id[IDX_W-1:0];
  assign w_slot_free = !r_mem_rts || mem_rtr;
  assign w_rtr_en    = (r_state == FBARB_STATE_GRANT) && w_slot_free;
  assign w_req_xfc   = w_rtr_en && w_owner_rts;

  // Owner's beat and handshake signals, selected by the current grant.
  always_comb begin
    w_sel_addr  = {ADDR_W{1'b0}};
    w_sel_data  = {DATA_W{1'b0}};
    w_sel_wben  = {WB_W{1'b0}};
    w_owner_rts = 1'b0;
    req_rtr     = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_addr  = (IDX_W'(i) == w_gidx) ? req_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
      w_sel_data  = (IDX_W'(i) == w_gidx) ? req_data[i*DATA_W +: DATA_W] : w_sel_data;
      w_sel_wben  = (IDX_W'(i) == w_gidx) ? req_wben[i*WB_W +: WB_W]     : w_sel_wben;
      w_owner_rts = (IDX_W'(i) == w_gidx) ? req_rts[i]                   : w_owner_rts;
      req_rtr[i]  = w_rtr_en && (IDX_W'(i) == w_gidx);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_burst_cnt;
    w_busy_nxt  = r_busy;
    w_release   = 1'b0;
    case (r_state)
      FBARB_STATE_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = FBARB_STATE_GRANT;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      FBARB_STATE_GRANT: begin
        // A dropped request ends the burst even if the slot is blocked.
        if (!w_owner_rts) begin
          w_release = 1'b1;
        end else if (w_req_xfc) begin
          if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            w_release = 1'b1;
          end else begin
            w_cnt_nxt = r_burst_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_burst_cnt;
        end
        if (w_release) begin
          w_last_nxt  = r_grant_id;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = FBARB_STATE_IDLE;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = FBARB_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= FBARB_STATE_IDLE;
      r_grant_id   <= {GID_W{1'b0}};
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_burst_cnt  <= {CNT_W{1'b0}};
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_mem_rts  <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mem_data <= {DATA_W{1'b0}};
      r_mem_wben <= {WB_W{1'b0}};
    end else if (w_req_xfc) begin
      r_mem_rts  <= 1'b1;
      r_mem_addr <= w_sel_addr;
      r_mem_data <= w_sel_data;
      r_mem_wben <= w_sel_wben;
    end else if (r_mem_rts && mem_rtr) begin
      r_mem_rts  <= 1'b0;
    end else begin
      r_mem_rts  <= r_mem_rts;
    end
  end

  assign mem_rts  = r_mem_rts;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_wben = r_mem_wben;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: accepted beats are queued and matched against the memory port,
// while a request-level model checks grant choice and burst lengths.
module tb_fb_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WB = DW / 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [WB-1:0] w;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_;
  logic [N-1:0]      req_rts;
  logic [N-1:0]      req_rtr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*WB-1:0]   req_wben;
  logic              mem_rts;
  logic              mem_rtr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic [WB-1:0]     mem_wben;
  logic [2:0]        grant_id;
  logic              busy;

  logic [AW-1:0] b_addr [N];
  logic [DW-1:0] b_data [N];
  logic [WB-1:0] b_wben [N];

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  int    grant_q[$];
  int    burst_len_q[$];
  int    acc_cnt [N];
  logic [N-1:0] acc;

  bit           prev_busy;
  logic [N-1:0] prev_rts;
  int           cur_owner;
  int           last_owner;
  int           beats;
  bit           hold_v;
  beat_t        hold_b;

  fb_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_(rst_),
    .req_rts(req_rts), .req_rtr(req_rtr),
    .req_addr(req_addr), .req_data(req_data), .req_wben(req_wben),
    .mem_rts(mem_rts), .mem_rtr(mem_rtr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wben(mem_wben),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = b_addr[i];
      req_data[i*DW +: DW] = b_data[i];
      req_wben[i*WB +: WB] = b_wben[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner from the arbitration rule: round-robin after last, or lowest index in fixed mode.
  function automatic int pick_model(input logic [N-1:0] r, input int last);
    int j;
`ifdef FBARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      if (((r >> k) & 1) != 0) return k;
    end
`else
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (((r >> j) & 1) != 0) return j;
    end
`endif
    return 0;
  endfunction

  // Monitor: samples on the falling edge, between the DUT's clock edges.
  always @(negedge clk) begin
    logic [N-1:0] exp_rtr;
    beat_t        got;
    if (!rst_) begin
      exp_q.delete();
      prev_busy  = 1'b0;
      prev_rts   = '0;
      last_owner = N - 1;
      cur_owner  = 0;
      beats      = 0;
      hold_v     = 1'b0;
      acc        = '0;
    end else begin
      got = {mem_addr, mem_data, mem_wben};
      if (mem_rts && mem_rtr) begin
        if (exp_q.size() == 0) chk("mem_beat_unexpected", 64'd1, 64'd0);
        else chk("mem_beat", 64'(got), 64'(exp_q.pop_front()));
      end
      if (hold_v) begin
        chk("hold_rts", 64'(mem_rts), 64'd1);
        chk("hold_beat", 64'(got), 64'(hold_b));
      end
      hold_v = mem_rts && !mem_rtr;
      hold_b = got;

      for (int i = 0; i < N; i++)
        exp_rtr[i] = busy && (!mem_rts || mem_rtr) && (grant_id == 3'(i));
      chk("req_rtr", 64'(req_rtr), 64'(exp_rtr));

      if (!prev_busy) begin
        chk("idle_grant", 64'(busy), 64'(prev_rts != '0));
        if (busy) begin
          chk("grant_pick", 64'(grant_id), 64'(pick_model(prev_rts, last_owner)));
          grant_q.push_back(int'(grant_id));
          cur_owner = int'(grant_id);
          beats     = 0;
        end
      end else if (busy) begin
        chk("grant_stable", 64'(grant_id), 64'(cur_owner));
        chk("release_due", 64'((beats >= MB) || (((prev_rts >> cur_owner) & 1) == 0)), 64'd0);
      end else begin
        chk("release_ok", 64'((beats == MB) || (((prev_rts >> cur_owner) & 1) == 0)), 64'd1);
        burst_len_q.push_back(beats);
        last_owner = cur_owner;
      end

      acc = req_rts & req_rtr;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          exp_q.push_back({b_addr[i], b_data[i], b_wben[i]});
          beats++;
        end
      end
      prev_busy = busy;
      prev_rts  = req_rts;
    end
  end

  task automatic new_beat(input int i);
    b_addr[i] = AW'($urandom);
    b_data[i] = DW'($urandom);
    b_wben[i] = WB'($urandom);
  endtask

  // One cycle: wait past the edge, refresh accepted beats, caller then drives new inputs.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc_cnt[i]++;
        new_beat(i);
      end
    end
  endtask

  initial begin
    int exp_g[5];
    rst_    = 1'b0;
    req_rts = '0;
    mem_rtr = 1'b0;
    for (int i = 0; i < N; i++) begin
      new_beat(i);
      acc_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rtr", 64'(req_rtr), 64'd0);
    chk("rst_mem_rts", 64'(mem_rts), 64'd0);
    chk("rst_mem_beat", 64'({mem_addr, mem_data, mem_wben}), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_ = 1'b1;

    // Requester 0 alone, 20 beats: a full burst, one idle cycle, then a short one.
    grant_q.delete();
    burst_len_q.delete();
    for (int c = 0; c < 100; c++) begin
      step();
      mem_rtr = 1'b1;
      req_rts = (acc_cnt[0] < 20) ? 4'b0001 : 4'b0000;
    end
    chk("p1_bursts", 64'(burst_len_q.size()), 64'd2);
    if (burst_len_q.size() == 2) begin
      chk("p1_len0", 64'(burst_len_q[0]), 64'(MB));
      chk("p1_len1", 64'(burst_len_q[1]), 64'd4);
    end
    chk("p1_grants", 64'(grant_q.size()), 64'd2);

    // All requesters continuous: rotation continues after the last owner (0).
    grant_q.delete();
    burst_len_q.delete();
    for (int c = 0; c < 90; c++) begin
      step();
      req_rts = 4'b1111;
    end
    step();
    req_rts = 4'b0000;
    repeat (5) step();
`ifdef FBARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{1, 2, 3, 0, 1};
`endif
    chk("p2_grant_cnt", 64'(grant_q.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_q.size()) chk("p2_grant_order", 64'(grant_q[k]), 64'(exp_g[k]));
      if (k < 4 && k < burst_len_q.size()) chk("p2_burst_len", 64'(burst_len_q[k]), 64'(MB));
    end

    // Memory stalls mid-burst, then reset while a beat is held.
    step();
    req_rts = 4'b0010;
    repeat (3) step();
    mem_rtr = 1'b0;
    repeat (5) step();
    chk("p3_held", 64'(mem_rts), 64'd1);
    #1;
    rst_    = 1'b0;
    req_rts = 4'b0000;
    #1;
    chk("p5_mem_rts", 64'(mem_rts), 64'd0);
    chk("p5_busy", 64'(busy), 64'd0);
    chk("p5_req_rtr", 64'(req_rtr), 64'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    grant_q.delete();
    step();
    req_rts = 4'b1111;
    mem_rtr = 1'b1;
    repeat (3) step();
    chk("p5_first_grant", 64'((grant_q.size() > 0) ? grant_q[0] : -1), 64'd0);

    // Randomised traffic with random memory backpressure.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_rts[i]) req_rts[i] = ($urandom_range(0, 7) != 0);
        else            req_rts[i] = ($urandom_range(0, 3) == 0);
      end
      mem_rtr = ($urandom_range(0, 9) < 7);
    end

    step();
    req_rts = '0;
    mem_rtr = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !mem_rts) break;
      step();
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_mem_rts", 64'(mem_rts), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
